// File: rtl/lcd_pkg.sv
// Shared definitions for the character LCD bus: state encoding, init command list,
// clear/home decode and the character codes used by the calculator line writers.
package lcd_pkg;

  localparam logic [2:0] S_PWR   = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_EHI   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_IDLE  = 3'd4;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;

  localparam logic [7:0] CH_DIGIT0 = 8'h30;
  localparam logic [7:0] CH_PLUS   = 8'h2B;
  localparam logic [7:0] CH_MINUS  = 8'h2D;
  localparam logic [7:0] CH_SLASH  = 8'h2F;
  localparam logic [7:0] CH_EQUAL  = 8'h3D;
  localparam logic [7:0] CH_BLANK  = 8'h20;

  // Clear (0x01) and home (0x02/0x03) need the long post-command wait.
  function automatic logic is_clr_home(input logic rs, input logic [7:0] data);
    return !rs && (data[7:2] == 6'd0);
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_ENTRY;
      default: return CMD_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester that did not win last time is granted.
module lcd_rr_arb2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  assign grant[0] = enable && valid0 && (!valid1 || last_grant);
  assign grant[1] = enable && valid1 && (!valid0 || !last_grant);

endmodule

// File: rtl/lcd_bus_scheduler.sv
// Sequences HD44780 power-up/init and arbitrated requester writes on the LCD bus,
// generating lcd_e with programmable setup, pulse and post-command wait times.
module lcd_bus_scheduler
  import lcd_pkg::*;
#(
  parameter int E_SETUP  = 2,
  parameter int E_HIGH   = 12,
  parameter int CMD_WAIT = 2000,
  parameter int CLR_WAIT = 80000,
  parameter int PWR_WAIT = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req0_ready,
  output logic       req1_ready,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data
);

  localparam int MAX_A   = (E_SETUP > E_HIGH) ? E_SETUP : E_HIGH;
  localparam int MAX_B   = (CMD_WAIT > CLR_WAIT) ? CMD_WAIT : CLR_WAIT;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_ALL = (MAX_C > PWR_WAIT) ? MAX_C : PWR_WAIT;
  localparam int CW      = $clog2(MAX_ALL) + 1;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          rs_q;
  logic [7:0]    data_q;
  logic          last_grant;
  logic [1:0]    grant;

  lcd_rr_arb2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .enable     ((state == S_IDLE) && init_done),
    .grant      (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign busy       = (state != S_IDLE);
  assign lcd_e      = (state == S_EHI);
  assign lcd_rs     = rs_q;
  assign lcd_data   = data_q;
  assign lcd_rw     = 1'b0;

  // Reset state is not a counted cycle, so PWR loads the full PWR_WAIT rather than PWR_WAIT-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_PWR;
      cnt        <= CW'(PWR_WAIT);
      idx        <= 2'd0;
      rs_q       <= 1'b0;
      data_q     <= 8'h00;
      init_done  <= 1'b0;
      last_grant <= 1'b1;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end else begin
      case (state)
        S_PWR: begin
          state  <= S_SETUP;
          cnt    <= CW'(E_SETUP - 1);
          idx    <= 2'd0;
          rs_q   <= 1'b0;
          data_q <= init_cmd(2'd0);
        end
        S_SETUP: begin
          state <= S_EHI;
          cnt   <= CW'(E_HIGH - 1);
        end
        S_EHI: begin
          state <= S_WAIT;
          cnt   <= is_clr_home(rs_q, data_q) ? CW'(CLR_WAIT - 1) : CW'(CMD_WAIT - 1);
        end
        S_WAIT: begin
          if (!init_done && idx != 2'd3) begin
            idx    <= idx + 2'd1;
            data_q <= init_cmd(idx + 2'd1);
            state  <= S_SETUP;
            cnt    <= CW'(E_SETUP - 1);
          end else begin
            init_done <= 1'b1;
            state     <= S_IDLE;
            cnt       <= '0;
          end
        end
        S_IDLE: begin
          if (grant[0]) begin
            rs_q       <= req0_rs;
            data_q     <= req0_data;
            last_grant <= 1'b0;
            state      <= S_SETUP;
            cnt        <= CW'(E_SETUP - 1);
          end else if (grant[1]) begin
            rs_q       <= req1_rs;
            data_q     <= req1_data;
            last_grant <= 1'b1;
            state      <= S_SETUP;
            cnt        <= CW'(E_SETUP - 1);
          end
        end
        default: begin
          state <= S_PWR;
          cnt   <= CW'(PWR_WAIT);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Bench for lcd_bus_scheduler: directed init/handshake/reset scenarios plus
// randomized two-requester traffic against a cycle-level transaction model.
module tb_lcd_bus_scheduler;

  localparam int ES   = 2;
  localparam int EH   = 4;
  localparam int CMD  = 10;
  localparam int CLR  = 30;
  localparam int PW   = 50;
  localparam int STEP = ES + EH + CMD;
  localparam int PER  = ES + EH + CMD + 1;
  localparam int DONE = PW + 4 * (ES + EH) + 3 * CMD + CLR;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] valid = 2'b00;
  logic [1:0] rs = 2'b00;
  logic [7:0] data [2];
  logic       req0_ready, req1_ready, init_done, busy, lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;

  int vectors = 0;
  int miscompares = 0;
  int cyc;
  logic [7:0] init_list [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};

  lcd_bus_scheduler #(
    .E_SETUP(ES), .E_HIGH(EH), .CMD_WAIT(CMD), .CLR_WAIT(CLR), .PWR_WAIT(PW)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(valid[0]), .req0_rs(rs[0]), .req0_data(data[0]),
    .req1_valid(valid[1]), .req1_rs(rs[1]), .req1_data(data[1]),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .init_done(init_done), .busy(busy),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) cyc <= -1;
    else     cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic reset_dut();
    valid = 2'b00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    data[0] = 8'hAA; data[1] = 8'h55; rs = 2'b11; valid = 2'b11;
    #2 rst = 1'b1;
    #1;
    vectors++; if (lcd_e !== 1'b0) begin miscompares++; $display("FAIL reset_lcd_e got=%b exp=0", lcd_e); end
    vectors++; if (lcd_rs !== 1'b0) begin miscompares++; $display("FAIL reset_lcd_rs got=%b exp=0", lcd_rs); end
    vectors++; if (lcd_rw !== 1'b0) begin miscompares++; $display("FAIL reset_lcd_rw got=%b exp=0", lcd_rw); end
    vectors++; if (lcd_data !== 8'h00) begin miscompares++; $display("FAIL reset_lcd_data got=%h exp=00", lcd_data); end
    vectors++; if ({req1_ready, req0_ready} !== 2'b00) begin miscompares++; $display("FAIL reset_ready got=%b exp=00", {req1_ready, req0_ready}); end
    vectors++; if (init_done !== 1'b0) begin miscompares++; $display("FAIL reset_init_done got=%b exp=0", init_done); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL reset_busy got=%b exp=1", busy); end
    valid = 2'b00;
  endtask

  // Checks cycles 0..140 after reset release against the init schedule.
  task automatic test_init_seq();
    int n, k;
    logic e_exp;
    logic [7:0] d_exp;
    for (int i = 0; i <= 140; i++) begin
      @(negedge clk);
      n = cyc;
      e_exp = 1'b0;
      for (int j = 0; j < 4; j++)
        if (n >= PW + ES + j * STEP && n < PW + ES + j * STEP + EH) e_exp = 1'b1;
      if (n < PW) d_exp = 8'h00;
      else begin
        k = (n - PW) / STEP;
        if (k > 3) k = 3;
        d_exp = init_list[k];
      end
      vectors++; if (lcd_e !== e_exp) begin miscompares++; $display("FAIL init_lcd_e cyc=%0d got=%b exp=%b", n, lcd_e, e_exp); end
      vectors++; if (lcd_data !== d_exp) begin miscompares++; $display("FAIL init_lcd_data cyc=%0d got=%h exp=%h", n, lcd_data, d_exp); end
      vectors++; if (lcd_rs !== 1'b0) begin miscompares++; $display("FAIL init_lcd_rs cyc=%0d got=%b exp=0", n, lcd_rs); end
      vectors++; if (init_done !== (n >= DONE)) begin miscompares++; $display("FAIL init_done cyc=%0d got=%b exp=%b", n, init_done, n >= DONE); end
      vectors++; if (busy !== (n < DONE)) begin miscompares++; $display("FAIL init_busy cyc=%0d got=%b exp=%b", n, busy, n < DONE); end
    end
  endtask

  task automatic test_init();
    reset_dut();
    test_init_seq();
  endtask

  task automatic test_back_to_back();
    int n, nxt, w, g;
    bit got, have_last;
    logic [7:0] last_d;
    @(posedge clk); #1;
    rs = 2'b11;
    data[0] = 8'($urandom_range(0, 255));
    data[1] = 8'($urandom_range(0, 255));
    valid = 2'b11;
    nxt = cyc; w = 0; got = 0; have_last = 0; g = 0; last_d = 8'h00;
    for (int i = 0; i < 6 * PER; i++) begin
      @(negedge clk);
      n = cyc;
      vectors++; if (req0_ready !== (n == nxt && w == 0)) begin miscompares++; $display("FAIL b2b_ready0 cyc=%0d got=%b exp=%b", n, req0_ready, n == nxt && w == 0); end
      vectors++; if (req1_ready !== (n == nxt && w == 1)) begin miscompares++; $display("FAIL b2b_ready1 cyc=%0d got=%b exp=%b", n, req1_ready, n == nxt && w == 1); end
      if (have_last) begin
        vectors++; if (lcd_data !== last_d) begin miscompares++; $display("FAIL b2b_data cyc=%0d got=%h exp=%h", n, lcd_data, last_d); end
      end
      if (n == nxt) begin
        last_d = data[w]; g = w; w = 1 - w; nxt = nxt + PER; got = 1; have_last = 1;
      end
      @(posedge clk); #1;
      if (got) begin data[g] = 8'($urandom_range(0, 255)); got = 0; end
    end
    valid = 2'b00;
  endtask

  // One requester writes a byte then immediately offers a second; checks timing of the first.
  task automatic test_write_pair(input int r, input logic rs1, input logic [7:0] d1, input int wait_len);
    int n, k, t, gap;
    logic rdy, other;
    gap = ES + EH + wait_len + 1;
    repeat (40) @(posedge clk);
    #1;
    rs[r] = rs1; data[r] = d1; valid[r] = 1'b1;
    t = cyc;
    for (int i = 0; i <= gap; i++) begin
      @(negedge clk);
      n = cyc; k = n - t;
      rdy   = (r == 0) ? req0_ready : req1_ready;
      other = (r == 0) ? req1_ready : req0_ready;
      vectors++; if (rdy !== (k == 0 || k == gap)) begin miscompares++; $display("FAIL wr%0d_ready k=%0d got=%b exp=%b", r, k, rdy, k == 0 || k == gap); end
      vectors++; if (other !== 1'b0) begin miscompares++; $display("FAIL wr%0d_other_ready k=%0d got=%b exp=0", r, k, other); end
      vectors++; if (lcd_e !== (k >= ES + 1 && k <= ES + EH)) begin miscompares++; $display("FAIL wr%0d_lcd_e k=%0d got=%b exp=%b", r, k, lcd_e, k >= ES + 1 && k <= ES + EH); end
      vectors++; if (busy !== (k >= 1 && k < gap)) begin miscompares++; $display("FAIL wr%0d_busy k=%0d got=%b exp=%b", r, k, busy, k >= 1 && k < gap); end
      if (k >= 1) begin
        vectors++; if (lcd_rs !== rs1) begin miscompares++; $display("FAIL wr%0d_lcd_rs k=%0d got=%b exp=%b", r, k, lcd_rs, rs1); end
        vectors++; if (lcd_data !== d1) begin miscompares++; $display("FAIL wr%0d_lcd_data k=%0d got=%h exp=%h", r, k, lcd_data, d1); end
      end
      @(posedge clk); #1;
      if (k == 0) begin rs[r] = 1'b1; data[r] = 8'h30; end
      if (k == gap) valid[r] = 1'b0;
    end
  endtask

  task automatic test_single_write();
    test_write_pair(0, 1'b1, 8'h41, CMD);
  endtask

  task automatic test_clear();
    test_write_pair(1, 1'b0, 8'h01, CLR);
  endtask

  task automatic test_early_req();
    int n;
    reset_dut();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (cyc == 10) begin rs[0] = 1'b1; data[0] = 8'h55; valid[0] = 1'b1; end
      if (cyc == DONE + 1) valid[0] = 1'b0;
      @(negedge clk);
      n = cyc;
      vectors++; if (req0_ready !== (n == DONE)) begin miscompares++; $display("FAIL early_ready0 cyc=%0d got=%b exp=%b", n, req0_ready, n == DONE); end
      if (n == DONE + 1) begin
        vectors++; if (lcd_data !== 8'h55) begin miscompares++; $display("FAIL early_lcd_data got=%h exp=55", lcd_data); end
        vectors++; if (lcd_rs !== 1'b1) begin miscompares++; $display("FAIL early_lcd_rs got=%b exp=1", lcd_rs); end
        break;
      end
    end
    valid = 2'b00;
  endtask

  task automatic test_rst_mid();
    repeat (40) @(posedge clk);
    #1;
    rs[0] = 1'b1; data[0] = 8'h7A; valid[0] = 1'b1;
    @(posedge clk); #1;
    valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (lcd_e !== 1'b1) begin miscompares++; $display("FAIL rstmid_e_before got=%b exp=1", lcd_e); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (lcd_e !== 1'b0) begin miscompares++; $display("FAIL rstmid_e_after got=%b exp=0", lcd_e); end
    vectors++; if (lcd_data !== 8'h00) begin miscompares++; $display("FAIL rstmid_data got=%h exp=00", lcd_data); end
    vectors++; if (lcd_rs !== 1'b0) begin miscompares++; $display("FAIL rstmid_rs got=%b exp=0", lcd_rs); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rstmid_busy got=%b exp=1", busy); end
    vectors++; if (init_done !== 1'b0) begin miscompares++; $display("FAIL rstmid_init_done got=%b exp=0", init_done); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_init_seq();
  endtask

  // Model: the bus is a resource free from free_at; each accepted write occupies it for a
  // duration set by its wait class, and ties go to the requester that lost last time.
  task automatic test_random();
    int n, g, pend, free_at, e_lo, e_hi, last, w;
    int gap [2];
    logic [7:0] exp_d;
    logic exp_rs, idle;
    reset_dut();
    while (cyc < 140) @(negedge clk);
    free_at = 0; e_lo = 1; e_hi = 0; last = 1; exp_rs = 1'b0; exp_d = 8'h01; pend = -1;
    gap[0] = 0; gap[1] = 3;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      if (pend >= 0) begin valid[pend] = 1'b0; gap[pend] = $urandom_range(0, 25); pend = -1; end
      for (int r = 0; r < 2; r++)
        if (!valid[r]) begin
          if (gap[r] > 0) gap[r]--;
          else begin
            if ($urandom_range(0, 3) == 0) begin rs[r] = 1'b0; data[r] = 8'($urandom_range(0, 3)); end
            else begin rs[r] = 1'($urandom_range(0, 1)); data[r] = 8'($urandom_range(0, 255)); end
            valid[r] = 1'b1;
          end
        end
      @(negedge clk);
      n = cyc;
      idle = (n >= free_at);
      g = -1;
      if (idle) begin
        if (valid[0] && valid[1]) g = (last == 1) ? 0 : 1;
        else if (valid[0]) g = 0;
        else if (valid[1]) g = 1;
      end
      vectors++; if (req0_ready !== (g == 0)) begin miscompares++; $display("FAIL rnd_ready0 cyc=%0d got=%b exp=%b", n, req0_ready, g == 0); end
      vectors++; if (req1_ready !== (g == 1)) begin miscompares++; $display("FAIL rnd_ready1 cyc=%0d got=%b exp=%b", n, req1_ready, g == 1); end
      vectors++; if (lcd_e !== (n >= e_lo && n <= e_hi)) begin miscompares++; $display("FAIL rnd_lcd_e cyc=%0d got=%b exp=%b", n, lcd_e, n >= e_lo && n <= e_hi); end
      vectors++; if (lcd_rs !== exp_rs) begin miscompares++; $display("FAIL rnd_lcd_rs cyc=%0d got=%b exp=%b", n, lcd_rs, exp_rs); end
      vectors++; if (lcd_data !== exp_d) begin miscompares++; $display("FAIL rnd_lcd_data cyc=%0d got=%h exp=%h", n, lcd_data, exp_d); end
      vectors++; if (busy !== !idle) begin miscompares++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", n, busy, !idle); end
      vectors++; if (lcd_rw !== 1'b0) begin miscompares++; $display("FAIL rnd_lcd_rw cyc=%0d got=%b exp=0", n, lcd_rw); end
      if (g >= 0) begin
        exp_rs = rs[g]; exp_d = data[g];
        w = (rs[g] == 1'b0 && data[g] < 8'd4) ? CLR : CMD;
        e_lo = n + ES + 1; e_hi = n + ES + EH;
        free_at = n + ES + EH + w + 1;
        last = g; pend = g;
      end
    end
    valid = 2'b00;
  endtask

  initial begin
    data[0] = 8'h00; data[1] = 8'h00;
    test_reset();
    test_init();
    test_back_to_back();
    test_single_write();
    test_clear();
    test_early_req();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
